// File: rtl/usb_host_if_pkg.sv
// Shared types and constants for the EPP-style USB host bus interface.
package usb_host_if_pkg;

  localparam int BUS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } bus_state_e;

  // Encoded as {is_addr, write}, so bit 1 selects the strobe and bit 0 the direction.
  typedef enum logic [1:0] {
    DATA_RD = 2'b00,
    DATA_WR = 2'b01,
    ADDR_RD = 2'b10,
    ADDR_WR = 2'b11
  } cycle_e;

  function automatic cycle_e cycle_of(input logic is_addr, input logic write);
    return cycle_e'({is_addr, write});
  endfunction

endpackage

// File: rtl/usb_host_if_sync.sv
// N-stage synchroniser for a single asynchronous control bit.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/usb_host_if.sv
// Host (initiator) side of the EPP-style byte bus: one command becomes one
// strobed bus cycle, completed on the responder's wait handshake or a timeout.
module usb_host_if
  import usb_host_if_pkg::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_is_addr,
  input  logic             cmd_write,
  input  logic [BUS_W-1:0] cmd_wdata,
  output logic             rsp_valid,
  output logic [BUS_W-1:0] rsp_rdata,
  output logic             rsp_timeout,
  output logic             usbAddrStrobe_n,
  output logic             usbDataStrobe_n,
  output logic             usbWE_n,
  inout  wire  [BUS_W-1:0] usbData,
  input  logic             usbWait
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  bus_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cycle_e           cyc_q, cyc_d;
  logic             astb_q, astb_d, dstb_q, dstb_d;
  logic             we_n_q, we_n_d, oe_q, oe_d;
  logic [BUS_W-1:0] dout_q, dout_d, rdata_q, rdata_d;
  logic             valid_q, valid_d, tmo_q, tmo_d;
  logic             ready_q, ready_d;
  logic             wait_s;
  logic             accept;
  logic             timeout_hit;

  sync_bit #(.STAGES(SYNC_STAGES)) u_wait_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (usbWait),
    .q     (wait_s)
  );

  // ready_q tracks "back in IDLE"; the live wait_s term keeps a still-busy responder gated.
  assign cmd_ready = ready_q & ~wait_s;
  assign accept    = cmd_valid & cmd_ready;
  assign timeout_hit = (cnt_q == TMO_LAST) &&
                       (((state_q == ST_STROBE) && !wait_s) ||
                        ((state_q == ST_RELEASE) && wait_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STROBE: begin
        if (wait_s) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!wait_s || timeout_hit) state_d = ST_IDLE;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_d   = cyc_q;
    we_n_d  = we_n_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    tmo_d   = 1'b0;
    ready_d = (state_d == ST_IDLE) && !wait_s;
    // Strobes follow the next state, so they are low exactly while STROBE is held.
    astb_d  = !((state_d == ST_STROBE) && cyc_q[1]);
    dstb_d  = !((state_d == ST_STROBE) && !cyc_q[1]);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cyc_d  = cycle_of(cmd_is_addr, cmd_write);
          we_n_d = ~cmd_write;
          oe_d   = cmd_write;
          dout_d = cmd_wdata;
        end
      end
      ST_STROBE: begin
        if (wait_s) begin
          if (!cyc_q[0]) rdata_d = usbData;
        end else if (timeout_hit) begin
          we_n_d  = 1'b1;
          oe_d    = 1'b0;
          valid_d = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!wait_s || timeout_hit) begin
          we_n_d  = 1'b1;
          oe_d    = 1'b0;
          valid_d = 1'b1;
          tmo_d   = wait_s;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= DATA_RD;
      astb_q  <= 1'b1;
      dstb_q  <= 1'b1;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      cyc_q   <= cyc_d;
      astb_q  <= astb_d;
      dstb_q  <= dstb_d;
      we_n_q  <= we_n_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      ready_q <= ready_d;
    end
  end

  assign usbAddrStrobe_n = astb_q;
  assign usbDataStrobe_n = dstb_q;
  assign usbWE_n         = we_n_q;
  assign usbData         = oe_q ? dout_q : {BUS_W{1'bz}};
  assign rsp_valid       = valid_q;
  assign rsp_timeout     = tmo_q;
  assign rsp_rdata       = rdata_q;

endmodule

// File: tb/tb_usb_host_if.sv
// Directed bench for usb_host_if against a small EPP responder model.
module tb_usb_host_if;

  localparam int SETUP = 2;
  localparam int TMO   = 15;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_is_addr = 1'b0, cmd_write = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_ready, rsp_valid, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       astb, dstb, we_n;
  wire  [7:0] usbData;
  logic       usbWait;

  always #5 clk = ~clk;

  usb_host_if #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_is_addr     (cmd_is_addr),
    .cmd_write       (cmd_write),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_timeout     (rsp_timeout),
    .usbAddrStrobe_n (astb),
    .usbDataStrobe_n (dstb),
    .usbWE_n         (we_n),
    .usbData         (usbData),
    .usbWait         (usbWait)
  );

  // Responder model: raises wait 2 clocks after a strobe falls, drops it 2 clocks after release.
  logic       per_en = 1'b0, wait_force = 1'b0;
  logic       per_wait = 1'b0, per_oe = 1'b0;
  logic [7:0] per_drv = 8'h00, per_addr = 8'h00, per_data = 8'h00;
  int         dly = 0;

  always @(posedge clk) begin
    if (!per_en) begin
      per_wait <= 1'b0;
      per_oe   <= 1'b0;
      dly      <= 0;
    end else if (!per_wait) begin
      if (!astb || !dstb) begin
        if (dly == 1) begin
          per_wait <= 1'b1;
          dly      <= 0;
          if (we_n) begin
            per_oe  <= 1'b1;
            per_drv <= !astb ? per_addr : per_data;
          end else if (!astb) per_addr <= usbData;
          else                per_data <= usbData;
        end else dly <= dly + 1;
      end else dly <= 0;
    end else begin
      if (astb && dstb) begin
        if (dly == 1) begin
          per_wait <= 1'b0;
          per_oe   <= 1'b0;
          dly      <= 0;
        end else dly <= dly + 1;
      end else dly <= 0;
    end
  end

  assign usbData = per_oe ? per_drv : 8'bzzzzzzzz;
  assign usbWait = wait_force ? 1'b1 : per_wait;

  // Bus monitor: counts responses and strobe edges, flags protocol violations.
  int         cyc = 0;
  int         n_valid = 0, n_afall = 0, n_dfall = 0, viol = 0;
  int         t_wefall = 0, t_sfall = 0, t_srise = 0;
  logic       p_we = 1'b1, p_a = 1'b1, p_d = 1'b1;
  logic       last_tmo = 1'b0;
  logic [7:0] last_rdata = 8'h00, cur_wdata = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid) begin
      n_valid    <= n_valid + 1;
      last_tmo   <= rsp_timeout;
      last_rdata <= rsp_rdata;
    end
    if (p_we && !we_n) t_wefall <= cyc;
    if (p_a && !astb) begin n_afall <= n_afall + 1; t_sfall <= cyc; end
    if (p_d && !dstb) begin n_dfall <= n_dfall + 1; t_sfall <= cyc; end
    if ((!p_a && astb) || (!p_d && dstb)) t_srise <= cyc;
    if ((!astb && !dstb) ||
        ((p_we != we_n) && ((!p_a && !astb) || (!p_d && !dstb))) ||
        (!we_n && usbData !== cur_wdata) ||
        (we_n && !per_oe && usbData !== 8'bzzzzzzzz))
      viol <= viol + 1;
    p_we <= we_n;
    p_a  <= astb;
    p_d  <= dstb;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!cmd_ready && k < 100) begin @(negedge clk); #1; k++; end
    check("cmd_ready_wait", cmd_ready, 1);
  endtask

  task automatic issue(input logic a, input logic w, input logic [7:0] d);
    cur_wdata   = d;
    wait_ready();
    cmd_valid   = 1'b1;
    cmd_is_addr = a;
    cmd_write   = w;
    cmd_wdata   = d;
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
  endtask

  task automatic do_cmd(input logic a, input logic w, input logic [7:0] d,
                        output int nv, output logic tmo, output logic [7:0] rd,
                        output int dt, output int da, output int dd);
    int n0, a0, d0, k;
    n0 = n_valid; a0 = n_afall; d0 = n_dfall;
    issue(a, w, d);
    k = 0;
    while (n_valid == n0 && k < 200) begin @(negedge clk); #1; k++; end
    repeat (6) @(negedge clk);
    #1;
    nv  = n_valid - n0;
    tmo = last_tmo;
    rd  = last_rdata;
    dt  = t_sfall - t_wefall;
    da  = n_afall - a0;
    dd  = n_dfall - d0;
  endtask

  typedef struct {
    logic       a;
    logic       w;
    logic [7:0] d;
    logic [7:0] exp_rd;
    logic [7:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, dt, da, dd, n, n0, a0, d0, nrdy;
    logic tmo;
    logic [7:0] rd;

    vecs[0] = '{1'b0, 1'b1, 8'hA5, 8'h00, 8'h00, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 8'h3C, 8'h00, 8'h3C, 8'hA5};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 8'h3C, 8'h3C, 8'hA5};
    vecs[3] = '{1'b0, 1'b1, 8'h5A, 8'h3C, 8'h3C, 8'h5A};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 8'h5A, 8'h3C, 8'h5A};
    vecs[5] = '{1'b1, 1'b1, 8'hC3, 8'h5A, 8'hC3, 8'h5A};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 8'hC3, 8'hC3, 8'h5A};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h5A, 8'hC3, 8'h5A};

    repeat (3) @(negedge clk);
    check("rst_astb", astb, 1);
    check("rst_dstb", dstb, 1);
    check("rst_we_n", we_n, 1);
    check("rst_data_z", usbData === 8'bzzzzzzzz, 1);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    rst_n  = 1'b1;
    per_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_cmd(vecs[i].a, vecs[i].w, vecs[i].d, nv, tmo, rd, dt, da, dd);
      check($sformatf("v%0d_nvalid", i), nv, 1);
      check($sformatf("v%0d_timeout", i), tmo, 0);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_per_addr", i), per_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_per_data", i), per_data, vecs[i].exp_data);
      check($sformatf("v%0d_astb_falls", i), da, vecs[i].a ? 1 : 0);
      check($sformatf("v%0d_dstb_falls", i), dd, vecs[i].a ? 0 : 1);
      if (vecs[i].w) check($sformatf("v%0d_we_to_strobe", i), dt, SETUP);
    end
    check("viol_normal", viol, 0);

    // No responder: read times out in STROBE and keeps the last read byte.
    per_en = 1'b0;
    do_cmd(1'b0, 1'b0, 8'h00, nv, tmo, rd, dt, da, dd);
    check("tmo_nvalid", nv, 1);
    check("tmo_flag", tmo, 1);
    check("tmo_rdata_kept", rd, 8'h5A);
    check("tmo_strobe_len", t_srise - t_sfall, TMO);

    // Stuck wait: RELEASE times out, then IDLE refuses commands until wait drops.
    n0 = n_valid;
    issue(1'b0, 1'b1, 8'h11);
    wait_force = 1'b1;
    n = 0;
    while (n_valid == n0 && n < 200) begin @(negedge clk); #1; n++; end
    check("stuck_nvalid", n_valid - n0, 1);
    check("stuck_timeout", last_tmo, 1);
    n0 = n_valid; a0 = n_afall; d0 = n_dfall; nrdy = 0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cmd_ready) nrdy++;
    end
    cmd_valid = 1'b0;
    check("stuck_ready_low", nrdy, 0);
    check("stuck_no_strobe", (n_afall - a0) + (n_dfall - d0), 0);
    check("stuck_no_rsp", n_valid - n0, 0);
    @(negedge clk);
    wait_force = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    check("stuck_ready_delay", n, SYNC + 1);

    // Reset while a write strobe is low.
    n0 = n_valid;
    issue(1'b0, 1'b1, 8'h99);
    n = 0;
    while (dstb && n < 20) begin @(negedge clk); #1; n++; end
    check("mid_strobe_low", dstb, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_astb", astb, 1);
    check("mid_rst_dstb", dstb, 1);
    check("mid_rst_we_n", we_n, 1);
    check("mid_rst_data_z", usbData === 8'bzzzzzzzz, 1);
    repeat (3) @(negedge clk);
    #1;
    check("mid_rst_no_rsp", n_valid - n0, 0);
    rst_n  = 1'b1;
    per_en = 1'b1;
    do_cmd(1'b0, 1'b1, 8'h42, nv, tmo, rd, dt, da, dd);
    check("post_rst_nvalid", nv, 1);
    check("post_rst_timeout", tmo, 0);
    check("post_rst_per_data", per_data, 8'h42);
    check("viol_total", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
